// File: rtl/axil_arb_pkg.sv
// Shared state encodings and sizing helper for the AXI-lite RAM arbiter.
package axil_arb_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_XFER = 2'd1,
    W_RESP = 2'd2
  } wstate_e;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_RESP = 2'd2
  } rstate_e;

  // Grant index width; kept at least 1 so a single-master build still has a legal vector.
  function automatic int arb_clog2(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_arb_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arb_pick #(
  parameter int N  = 2,
  parameter int GW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [GW-1:0] ptr,
  output logic [GW-1:0] grant,
  output logic          valid
);

  int idx;

  // ptr is always below N, so ptr+k never exceeds 2N-2 and one subtraction wraps it.
  always_comb begin
    grant = '0;
    valid = 1'b0;
    idx   = 0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!valid && req[idx]) begin
        valid = 1'b1;
        grant = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/axil_ram_arb.sv
// Round-robin sharing of one AXI-lite RAM port between S_COUNT masters,
// with independent single-outstanding read and write paths.
//
// state  | meaning
// W_IDLE | pick a write master from the awvalid vector
// W_XFER | forward granted AW and W, each until its own handshake
// W_RESP | route B back to the granted master, then advance the pointer
// R_IDLE | pick a read master from the arvalid vector
// R_ADDR | forward granted AR until its handshake
// R_RESP | route R back to the granted master, then advance the pointer
module axil_ram_arb
  import axil_arb_pkg::*;
#(
  parameter int S_COUNT    = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 16,
  parameter int STRB_WIDTH = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          rst_n,

  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [S_COUNT*3-1:0]          s_axil_awprot,
  input  logic [S_COUNT-1:0]            s_axil_awvalid,
  output logic [S_COUNT-1:0]            s_axil_awready,
  input  logic [S_COUNT*DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [S_COUNT*STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic [S_COUNT-1:0]            s_axil_wvalid,
  output logic [S_COUNT-1:0]            s_axil_wready,
  output logic [S_COUNT*2-1:0]          s_axil_bresp,
  output logic [S_COUNT-1:0]            s_axil_bvalid,
  input  logic [S_COUNT-1:0]            s_axil_bready,
  input  logic [S_COUNT*ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [S_COUNT*3-1:0]          s_axil_arprot,
  input  logic [S_COUNT-1:0]            s_axil_arvalid,
  output logic [S_COUNT-1:0]            s_axil_arready,
  output logic [S_COUNT*DATA_WIDTH-1:0] s_axil_rdata,
  output logic [S_COUNT*2-1:0]          s_axil_rresp,
  output logic [S_COUNT-1:0]            s_axil_rvalid,
  input  logic [S_COUNT-1:0]            s_axil_rready,

  output logic [ADDR_WIDTH-1:0]         m_axil_awaddr,
  output logic [2:0]                    m_axil_awprot,
  output logic                          m_axil_awvalid,
  input  logic                          m_axil_awready,
  output logic [DATA_WIDTH-1:0]         m_axil_wdata,
  output logic [STRB_WIDTH-1:0]         m_axil_wstrb,
  output logic                          m_axil_wvalid,
  input  logic                          m_axil_wready,
  input  logic [1:0]                    m_axil_bresp,
  input  logic                          m_axil_bvalid,
  output logic                          m_axil_bready,
  output logic [ADDR_WIDTH-1:0]         m_axil_araddr,
  output logic [2:0]                    m_axil_arprot,
  output logic                          m_axil_arvalid,
  input  logic                          m_axil_arready,
  input  logic [DATA_WIDTH-1:0]         m_axil_rdata,
  input  logic [1:0]                    m_axil_rresp,
  input  logic                          m_axil_rvalid,
  output logic                          m_axil_rready
);

  localparam int            GW   = arb_clog2(S_COUNT);
  localparam logic [GW-1:0] LAST = GW'(S_COUNT - 1);

  wstate_e       wstate_q, wstate_d;
  logic [GW-1:0] wgrant_q, wgrant_d, wptr_q, wptr_d, wpick;
  logic          wpick_v;
  logic          aw_done_q, aw_done_d, w_done_q, w_done_d;

  rstate_e       rstate_q, rstate_d;
  logic [GW-1:0] rgrant_q, rgrant_d, rptr_q, rptr_d, rpick;
  logic          rpick_v;

  rr_arb_pick #(.N(S_COUNT), .GW(GW)) u_wpick (
    .req   (s_axil_awvalid),
    .ptr   (wptr_q),
    .grant (wpick),
    .valid (wpick_v)
  );

  rr_arb_pick #(.N(S_COUNT), .GW(GW)) u_rpick (
    .req   (s_axil_arvalid),
    .ptr   (rptr_q),
    .grant (rpick),
    .valid (rpick_v)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wstate_q  <= W_IDLE;
      wgrant_q  <= '0;
      wptr_q    <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
      rstate_q  <= R_IDLE;
      rgrant_q  <= '0;
      rptr_q    <= '0;
    end else begin
      wstate_q  <= wstate_d;
      wgrant_q  <= wgrant_d;
      wptr_q    <= wptr_d;
      aw_done_q <= aw_done_d;
      w_done_q  <= w_done_d;
      rstate_q  <= rstate_d;
      rgrant_q  <= rgrant_d;
      rptr_q    <= rptr_d;
    end
  end

  // Write path: AW and W complete independently; done flags mask each valid once taken.
  always_comb begin
    wstate_d       = wstate_q;
    wgrant_d       = wgrant_q;
    wptr_d         = wptr_q;
    aw_done_d      = aw_done_q;
    w_done_d       = w_done_q;
    m_axil_awaddr  = s_axil_awaddr[int'(wgrant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    m_axil_awprot  = s_axil_awprot[int'(wgrant_q)*3 +: 3];
    m_axil_wdata   = s_axil_wdata[int'(wgrant_q)*DATA_WIDTH +: DATA_WIDTH];
    m_axil_wstrb   = s_axil_wstrb[int'(wgrant_q)*STRB_WIDTH +: STRB_WIDTH];
    m_axil_awvalid = 1'b0;
    m_axil_wvalid  = 1'b0;
    m_axil_bready  = 1'b0;
    s_axil_awready = '0;
    s_axil_wready  = '0;
    s_axil_bresp   = '0;
    s_axil_bvalid  = '0;
    case (wstate_q)
      W_IDLE: begin
        if (wpick_v) begin
          wgrant_d  = wpick;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_XFER;
        end
      end
      W_XFER: begin
        m_axil_awvalid           = !aw_done_q && s_axil_awvalid[wgrant_q];
        m_axil_wvalid            = !w_done_q && s_axil_wvalid[wgrant_q];
        s_axil_awready[wgrant_q] = !aw_done_q && m_axil_awready;
        s_axil_wready[wgrant_q]  = !w_done_q && m_axil_wready;
        aw_done_d = aw_done_q || (m_axil_awvalid && m_axil_awready);
        w_done_d  = w_done_q || (m_axil_wvalid && m_axil_wready);
        if (aw_done_d && w_done_d) wstate_d = W_RESP;
      end
      W_RESP: begin
        m_axil_bready                          = s_axil_bready[wgrant_q];
        s_axil_bvalid[wgrant_q]                = m_axil_bvalid;
        s_axil_bresp[int'(wgrant_q)*2 +: 2]    = m_axil_bresp;
        if (m_axil_bvalid && s_axil_bready[wgrant_q]) begin
          wptr_d    = (wgrant_q == LAST) ? '0 : wgrant_q + GW'(1);
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
          wstate_d  = W_IDLE;
        end
      end
      default: wstate_d = W_IDLE;
    endcase
  end

  always_comb begin
    rstate_d       = rstate_q;
    rgrant_d       = rgrant_q;
    rptr_d         = rptr_q;
    m_axil_araddr  = s_axil_araddr[int'(rgrant_q)*ADDR_WIDTH +: ADDR_WIDTH];
    m_axil_arprot  = s_axil_arprot[int'(rgrant_q)*3 +: 3];
    m_axil_arvalid = 1'b0;
    m_axil_rready  = 1'b0;
    s_axil_arready = '0;
    s_axil_rdata   = '0;
    s_axil_rresp   = '0;
    s_axil_rvalid  = '0;
    case (rstate_q)
      R_IDLE: begin
        if (rpick_v) begin
          rgrant_d = rpick;
          rstate_d = R_ADDR;
        end
      end
      R_ADDR: begin
        m_axil_arvalid           = s_axil_arvalid[rgrant_q];
        s_axil_arready[rgrant_q] = m_axil_arready;
        if (m_axil_arvalid && m_axil_arready) rstate_d = R_RESP;
      end
      R_RESP: begin
        m_axil_rready                                          = s_axil_rready[rgrant_q];
        s_axil_rvalid[rgrant_q]                                = m_axil_rvalid;
        s_axil_rdata[int'(rgrant_q)*DATA_WIDTH +: DATA_WIDTH]  = m_axil_rdata;
        s_axil_rresp[int'(rgrant_q)*2 +: 2]                    = m_axil_rresp;
        if (m_axil_rvalid && s_axil_rready[rgrant_q]) begin
          rptr_d   = (rgrant_q == LAST) ? '0 : rgrant_q + GW'(1);
          rstate_d = R_IDLE;
        end
      end
      default: rstate_d = R_IDLE;
    endcase
  end

endmodule

// File: doc/axil_ram_arb.md
# axil_ram_arb

Round-robin arbiter that shares one AXI-lite slave port (an `axil_ram` instance) between `S_COUNT` AXI-lite masters. Read and write paths are arbitrated independently, with one outstanding transaction per path. Valid/ready are passed through combinationally to the granted master only. It sits between the register/DMA-descriptor masters and the shared scratch RAM.

## Interface
- `S_COUNT`, 2: number of upstream masters (2–16).
- `DATA_WIDTH`, 32: data bus width.
- `ADDR_WIDTH`, 16: address width.
- `STRB_WIDTH`, `DATA_WIDTH/8`: write strobe width.

Ports:
- `clk`  in  1  clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `s_axil_aw{addr,prot,valid,ready}`  in/in/in/out  `S_COUNT`×{`ADDR_WIDTH`,3,1,1}  upstream write address; concatenated, master i at slice i.
- `s_axil_w{data,strb,valid,ready}`  in/in/in/out  `S_COUNT`×{`DATA_WIDTH`,`STRB_WIDTH`,1,1}  upstream write data.
- `s_axil_b{resp,valid,ready}`  out/out/in  `S_COUNT`×{2,1,1}  upstream write response.
- `s_axil_ar{addr,prot,valid,ready}`  in/in/in/out  `S_COUNT`×{`ADDR_WIDTH`,3,1,1}  upstream read address.
- `s_axil_r{data,resp,valid,ready}`  out/out/out/in  `S_COUNT`×{`DATA_WIDTH`,2,1,1}  upstream read data.
- `m_axil_aw*`, `m_axil_w*`, `m_axil_b*`, `m_axil_ar*`, `m_axil_r*`  mirrored directions, single-width  downstream port to RAM.

## Operation
- Write FSM: `W_IDLE` → `W_XFER` → `W_RESP` → `W_IDLE`.
  - `W_IDLE`: request vector = `s_axil_awvalid`. If any bit is set, the round-robin picker registers `wgrant` and the FSM enters `W_XFER`.
  - `W_XFER`: the granted master's AW and W are forwarded to `m_axil_aw*` / `m_axil_w*`. Each channel completes independently; sticky `aw_done` / `w_done` flags mask the valid after completion. When both are done, go to `W_RESP`.
  - `W_RESP`: `m_axil_b*` is routed to the granted slice. On `bvalid & bready`, the pointer advances to `wgrant+1` (mod `S_COUNT`) and the FSM returns to `W_IDLE`.
- Read FSM: `R_IDLE` → `R_ADDR` → `R_RESP` → `R_IDLE`. Same structure using `arvalid`, the AR handshake, then the R handshake.
- Round-robin: the search starts at the pointer and takes the first set request bit, wrapping. The pointer resets to 0.
- Non-granted slices: all readies and valids are 0; data/resp outputs are don't-care and driven 0.
- `m_axil_*valid` is asserted only in `W_XFER`/`R_ADDR` (address/data) and is never asserted in IDLE. `m_axil_bready`/`rready` are asserted only in the RESP state.
- `bresp`, `rresp`, `rdata`, `prot` and `strb` pass through unmodified.
- Read and write paths are fully independent. A simultaneous read and write, even from the same master, proceed in parallel.

## Timing
- Reset (async assert, sync release): FSMs go to IDLE, grants and pointers to 0, `aw_done`/`w_done` cleared. All `s_axil_*ready`, `s_axil_bvalid`, `s_axil_rvalid`, `m_axil_*valid`, `m_axil_bready` and `m_axil_rready` are 0.
- Arbitration latency: 1 cycle. A request seen in IDLE at edge N gives `m_axil_awvalid`/`arvalid` high after edge N+1.
- Path is combinational from granted `s` valid/ready to `m` valid/ready. No extra register stage.
- A request deasserted before grant is legal. The grant is computed only from the IDLE-cycle request vector.
- Reset mid-transaction abandons the transaction. The RAM must share the reset.
- Minimum per-path occupancy is 3 cycles (IDLE, XFER/ADDR, RESP), given zero-wait RAM and masters.

## Structure
- Shared package `axil_arb_pkg` holds the state encodings `W_IDLE`/`W_XFER`/`W_RESP` and `R_IDLE`/`R_ADDR`/`R_RESP` (2-bit), plus a clog2 helper for the grant width.
- One sub-module, `rr_arb_pick`: combinational round-robin picker. Inputs are the request vector and the pointer; outputs are the grant index and a valid flag. It is instantiated twice (read and write).

## Test plan
- Single master 0 writes 0xDEADBEEF to 0x0010 (strb 0xF), then reads 0x0010. Expect `s_axil_bresp[1:0]`=0 and `rdata`=0xDEADBEEF on slice 0. Slice 1 readies stay 0 throughout.
- Both masters assert AW/W in the same cycle after reset, to 0x0020 and 0x0024. Expect master 0 granted first, then master 1. Read-back gives both values.
- Master 0 requests continuously while master 1 requests once. Expect master 1 granted on the second arbitration (fairness).
- Concurrent read by master 1 and write by master 0 in the same cycle. Expect both `m_axil_arvalid` and `m_axil_awvalid` high one cycle later.
- W presented 3 cycles before AW, with strb 0x3 over 0xFFFFFFFF, writing 0x12345678. Expect a single transaction and read-back 0xFFFF5678.
- Assert `rst_n`=0 during `W_RESP` with `bready`=0. Expect all valids to drop immediately and a new request granted to master 0 after release.
